// File: rtl/toggle_event_tx.sv
// Toggle-encoded event transmitter.
// Each accepted event is sent as one transition on toggle_out. A far-end
// both-edge detector turns each transition back into a pulse. Transitions
// are spaced at least HOLD_CYCLES+1 cycles apart. Events that arrive while
// the line is busy wait in a saturating pending counter.
//
// state | meaning
// IDLE  | free to issue a transition
// HOLD  | spacing after a transition; hold counter counts down to 0
module toggle_event_tx #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             event_in,
    input  logic             enable,
    input  logic             clr_ovf,
    output logic             toggle_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       w_hold_cnt_nxt;
    logic             r_toggle;
    logic             w_toggle_nxt;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pending_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;
    logic             w_issue;
    logic             w_drop;

    // Register all state; reset discards outstanding events and spacing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 8'd0;
            r_toggle   <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_toggle   <= w_toggle_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Next-state logic: issue decision, hold countdown, pending bookkeeping.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_toggle_nxt   = r_toggle;
        w_pending_nxt  = r_pending;
        w_overflow_nxt = r_overflow;

        // A same-cycle event may be issued directly, bypassing the counter.
        w_issue = (r_state == ST_IDLE) && enable && ((r_pending != '0) || event_in);
        w_drop  = event_in && !w_issue && (r_pending == PEND_MAX);

        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_toggle_nxt   = ~r_toggle;
                    w_hold_cnt_nxt = HOLD_LOAD;
                    w_state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Issue and arrival in the same cycle cancel out.
        if (w_issue && !event_in) begin
            w_pending_nxt = r_pending - CNT_W'(1);
        end else if (event_in && !w_issue && !w_drop) begin
            w_pending_nxt = r_pending + CNT_W'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end else if (clr_ovf) begin
            w_overflow_nxt = 1'b0;
        end
    end

    assign toggle_out = r_toggle;
    assign pending    = r_pending;
    assign overflow   = r_overflow;
    assign busy       = (r_state == ST_HOLD) || (r_pending != '0);

endmodule

// File: tb/tb_toggle_event_tx.sv
// Bench for toggle_event_tx: directed scenarios plus random traffic, each
// cycle compared against a timeline model of the transmitter.
module tb_toggle_event_tx;

    localparam int HOLD = 2;
    localparam int CW   = 2;
    localparam int MAXP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          event_in;
    logic          enable;
    logic          clr_ovf;
    logic          toggle_out;
    logic [CW-1:0] pending;
    logic          busy;
    logic          overflow;

    toggle_event_tx #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .event_in   (event_in),
        .enable     (enable),
        .clr_ovf    (clr_ovf),
        .toggle_out (toggle_out),
        .pending    (pending),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: the line is free again HOLD+1 cycles after an issue.
    int   m_pend   = 0;
    bit   m_tog    = 1'b0;
    bit   m_ovf    = 1'b0;
    int   m_next   = 0;

    int   edges_q[$];
    logic prev_tog = 1'b0;
    int   peak     = 0;
    int   c0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ev, input bit en, input bit clr, input bit rst);
        bit idle;
        bit issue;
        int np;
        event_in = ev;
        enable   = en;
        clr_ovf  = clr;
        rst_n    = rst;
        @(posedge clk);
        if (!rst) begin
            m_tog  = 1'b0;
            m_pend = 0;
            m_ovf  = 1'b0;
            m_next = 0;
        end else begin
            idle  = (cyc >= m_next);
            issue = idle && en && (m_pend > 0 || ev);
            if (issue) begin
                m_tog  = ~m_tog;
                m_next = cyc + HOLD + 1;
            end
            np = m_pend + int'(ev) - int'(issue);
            if (np > MAXP) begin
                np    = MAXP;
                m_ovf = 1'b1;
            end else if (clr) begin
                m_ovf = 1'b0;
            end
            m_pend = np;
        end
        cyc++;
        @(negedge clk);
        if (toggle_out !== prev_tog) edges_q.push_back(cyc);
        prev_tog = toggle_out;
        if (int'(pending) > peak) peak = int'(pending);
        chk("toggle_out", 32'(toggle_out), 32'(m_tog));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("busy", 32'(busy), 32'((cyc < m_next) || (m_pend != 0)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        event_in = 1'b0;
        enable   = 1'b0;
        clr_ovf  = 1'b0;
        @(negedge clk);

        // Reset, with inputs active to show they are ignored.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_toggle", 32'(toggle_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        idle_n(3);

        // Single event: transition next cycle, busy for HOLD cycles.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("single_tog", 32'(toggle_out), 32'd1);
        chk("single_busy1", 32'(busy), 32'd1);
        chk("single_pend", 32'(pending), 32'd0);
        idle_n(1);
        chk("single_busy2", 32'(busy), 32'd1);
        idle_n(1);
        chk("single_busy3", 32'(busy), 32'd0);

        // Burst of four back-to-back events.
        idle_n(2);
        edges_q.delete();
        peak = 0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        idle_n(10);
        chk("burst_edges", 32'(edges_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < edges_q.size(); i++)
            chk("burst_edge_cycle", 32'(edges_q[i] - c0), 32'(1 + 3 * i));
        chk("burst_peak", 32'(peak), 32'd2);
        chk("burst_ovf", 32'(overflow), 32'd0);

        // Saturation with issue stalled, then drain.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("sat_pend", 32'(pending), 32'd3);
        chk("sat_ovf", 32'(overflow), 32'd1);
        edges_q.delete();
        idle_n(10);
        chk("drain_edges", 32'(edges_q.size()), 32'd3);
        for (int i = 1; i < edges_q.size(); i++)
            chk("drain_spacing", 32'(edges_q[i] - edges_q[i-1]), 32'd3);
        chk("drain_pend", 32'(pending), 32'd0);

        // Clear versus simultaneous drop.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_alone_a", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("fill_pend", 32'(pending), 32'd3);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("set_wins", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_alone_b", 32'(overflow), 32'd0);

        // Reset mid-HOLD with two events pending.
        idle_n(12);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_pend", 32'(pending), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_tog", 32'(toggle_out), 32'd0);
        chk("post_rst_pend", 32'(pending), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        edges_q.delete();
        idle_n(8);
        chk("post_rst_edges", 32'(edges_q.size()), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++)
            step(1'($urandom % 2), 1'($urandom % 4 != 0), 1'($urandom % 8 == 0),
                 1'($urandom % 64 != 0));

        // Round trip: 20 spaced pulses through a both-edge detector.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        edges_q.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            idle_n(int'($urandom_range(2, 5)));
        end
        idle_n(6);
        chk("roundtrip_pulses", 32'(edges_q.size()), 32'd20);
        chk("roundtrip_ovf", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toggle_event_tx.md
TOGGLE_EVENT_TX -- requirements
Module: toggle_event_tx

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: minimum number of cycles toggle_out SHALL stay stable after each transition; legal values are 1..255.
REQ-002 Parameter CNT_W, default 4: width of the pending-event counter; maximum count is 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all logic SHALL be on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 event_in  input  1  event request; each cycle it is high SHALL count as one event.
REQ-006 enable  input  1  high permits new toggle_out transitions; low stalls issue only.
REQ-007 clr_ovf  input  1  one-cycle clear strobe for overflow.
REQ-008 toggle_out  output  1  toggle-encoded event line; each transition is one event, for a both-edge detector at the far end.
REQ-009 pending  output  CNT_W  accepted events not yet issued (registered).
REQ-010 busy  output  1  high when state is HOLD or pending != 0 (combinational from registers).
REQ-011 overflow  output  1  sticky flag: at least one event was dropped.

Function
REQ-012 The FSM SHALL have two states: IDLE (free to issue) and HOLD (spacing in progress).
REQ-013 Issue condition SHALL be: state == IDLE && enable && (pending != 0 || event_in).
REQ-014 On an issue cycle, toggle_out SHALL invert at that clock edge, the hold counter SHALL load HOLD_CYCLES-1, and the state SHALL go to HOLD.
REQ-015 Issue latency from IDLE with pending == 0 SHALL be 1 cycle: event_in high in cycle N gives a toggle_out change visible in cycle N+1.
REQ-016 If event_in and an issue occur in the same cycle with pending == 0, the event SHALL be consumed directly and pending SHALL stay 0.
REQ-017 If event_in and an issue occur in the same cycle with pending != 0, pending SHALL be unchanged (+1 and -1 net zero); FIFO order is implied because events carry no data.
REQ-018 Issue without event_in SHALL decrement pending; event_in without issue SHALL increment pending.
REQ-019 In HOLD, the hold counter SHALL decrement each cycle; when it is 0, the state SHALL return to IDLE on the next edge. HOLD_CYCLES = 1 means one HOLD cycle.
REQ-020 Spacing: consecutive toggle_out transitions SHALL be at least HOLD_CYCLES+1 cycles apart; with back-to-back demand they SHALL be exactly HOLD_CYCLES+1 apart.
REQ-021 enable low SHALL block new issues only: HOLD still counts down and events are still counted into pending.
REQ-022 If pending is at maximum and event_in arrives without a same-cycle issue, the event SHALL be dropped, pending SHALL hold at maximum, and overflow SHALL set on the next edge.
REQ-023 When clr_ovf is high, overflow SHALL clear; if a drop happens in the same cycle, set SHALL win.
REQ-024 pending SHALL never wrap below 0 or above maximum.

Reset
REQ-025 While rst_n is low at a rising edge: toggle_out=0, pending=0, overflow=0, hold counter=0, state=IDLE; busy therefore reads 0.
REQ-026 Reset mid-HOLD or with pending != 0 SHALL discard all outstanding events; no toggle_out transition SHALL occur in the cycle after reset is released unless event_in and enable are high during that first released cycle.
REQ-027 Inputs SHALL be ignored while rst_n is low.

Verification (HOLD_CYCLES=2, CNT_W=2, max pending 3)
REQ-028 Single event: enable=1, one-cycle event_in at cycle 10 -> toggle_out 0->1 visible at cycle 11; pending stays 0; busy high cycles 11-12 and low at 13.
REQ-029 Burst: event_in high cycles 10-13 (4 events) -> toggle_out transitions at cycles 11, 14, 17, 20; pending peaks at 2; overflow stays 0.
REQ-030 Saturation: enable=0, event_in high for 5 cycles -> pending=3 and overflow=1; after enable=1, exactly 3 transitions 3 cycles apart and pending ends at 0.
REQ-031 Clear vs. set: with pending=3 and enable=0, assert clr_ovf and event_in together -> overflow stays 1; clr_ovf alone on the next cycle -> overflow=0.
REQ-032 Reset mid-operation: pending=2 in HOLD, rst_n low for 1 cycle -> toggle_out=0, pending=0, busy=0 and no further transitions.
REQ-033 Round trip: drive toggle_out into a both-edge detector and apply 20 random event_in pulses with no overflow -> exactly 20 detector output pulses.
